// File: rtl/common.sv
// rtl/common.sv - shared types for the fetch stage
// Purpose: word types, fetch FSM state encoding and the fetch output record
//          shared by the fetch controller, its skid buffer and the bench.
// Ports:   none (package)
package common;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // One fetched instruction. Used for the decode-facing output register and
  // for the one-entry skid register.
  typedef struct packed {
    logic valid;
    u64   pc;
    u32   instr;
  } fetch_out_t;

  localparam u64 PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry skid register for the fetch stage
// Purpose: holds one returned instruction while decode is stalled.
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_load       capture i_load_data (entry becomes valid)
//   i_load_data  instruction record to capture
//   i_drain      entry has been moved to the output register
//   i_clear      discard the entry (redirect)
//   o_skid       current entry
module fetch_skid
  import common::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  fetch_out_t i_load_data,
  input  logic       i_drain,
  input  logic       i_clear,
  output fetch_out_t o_skid
);

  fetch_out_t r_skid;

  // Clear beats load beats drain; pc/instr are left in place on drain/clear
  // since only the valid bit is meaningful afterwards.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_skid <= '0;
    end else if (i_clear) begin
      r_skid.valid <= 1'b0;
    end else if (i_load) begin
      r_skid <= i_load_data;
    end else if (i_drain) begin
      r_skid.valid <= 1'b0;
    end
  end

  assign o_skid = r_skid;

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - fetch-stage controller: PC, imem requests, decode handoff
// Purpose: owns the program counter, issues instruction-memory requests,
//          delivers instructions to decode, buffers one instruction under a
//          decode stall and discards fetches made stale by a redirect.
// Ports:
//   i_clk            clock, rising edge
//   i_reset          asynchronous active-high reset
//   o_pcplus4        pc + 4 (combinational), feeds the PC-select mux
//   i_pc_selected    next pc chosen by the PC-select mux
//   i_redirect       PC-select took the branch target this cycle
//   o_ireq_valid     instruction fetch request
//   o_ireq_addr      fetch address (= pc)
//   i_iresp_data_ok  response for the current request, accepted same cycle
//   i_iresp_data     instruction word
//   o_f_valid        instruction available to decode
//   o_f_pc           pc of o_f_instr
//   o_f_instr        fetched instruction
//   i_d_ready        decode accepts o_f_* this cycle
module ifetch_ctrl
  import common::*;
#(
  parameter u64 PC_RESET = 64'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [63:0] o_pcplus4,
  input  logic [63:0] i_pc_selected,
  input  logic        i_redirect,
  output logic        o_ireq_valid,
  output logic [63:0] o_ireq_addr,
  input  logic        i_iresp_data_ok,
  input  logic [31:0] i_iresp_data,
  output logic        o_f_valid,
  output logic [63:0] o_f_pc,
  output logic [31:0] o_f_instr,
  input  logic        i_d_ready
);

  fetch_state_t r_state;
  fetch_state_t w_state_n;
  u64           r_pc;
  u64           w_pc_n;
  u64           r_pc_pending;
  u64           w_pc_pending_n;
  fetch_out_t   r_f;
  fetch_out_t   w_f_n;
  fetch_out_t   w_skid;
  fetch_out_t   w_resp;
  logic         w_skid_load;
  logic         w_skid_drain;
  logic         w_skid_clear;
  logic         w_slot_free;

  assign o_pcplus4   = r_pc + PC_STEP;
  assign o_ireq_addr = r_pc;
  // Gate with reset so an abandoned request disappears the moment reset rises.
  assign o_ireq_valid = !i_reset && ((r_state == FETCH) || (r_state == FLUSH));

  assign w_slot_free = !r_f.valid || i_d_ready;
  assign w_resp      = '{valid: 1'b1, pc: r_pc, instr: i_iresp_data};

  fetch_skid u_skid (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_skid_load),
    .i_load_data (w_resp),
    .i_drain     (w_skid_drain),
    .i_clear     (w_skid_clear),
    .o_skid      (w_skid)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= FETCH;
      r_pc         <= PC_RESET;
      r_pc_pending <= '0;
      r_f          <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_pc_pending <= w_pc_pending_n;
      r_f          <= w_f_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_pc_pending_n = r_pc_pending;
    w_f_n          = r_f;
    w_skid_load    = 1'b0;
    w_skid_drain   = 1'b0;
    w_skid_clear   = 1'b0;

    // Decode consumed the current output; a load below may refill it.
    if (i_d_ready) begin
      w_f_n.valid = 1'b0;
    end

    // A redirect empties both buffers; no output load happens this cycle.
    if (i_redirect) begin
      w_f_n.valid  = 1'b0;
      w_skid_clear = 1'b1;
    end

    case (r_state)
      FETCH: begin
        if (i_redirect) begin
          if (i_iresp_data_ok) begin
            w_pc_n = i_pc_selected;
          end else begin
            // Request must stay stable until its response; remember target.
            w_pc_pending_n = i_pc_selected;
            w_state_n      = FLUSH;
          end
        end else if (i_iresp_data_ok) begin
          w_pc_n = i_pc_selected;
          if (w_slot_free) begin
            w_f_n = w_resp;
          end else begin
            w_skid_load = 1'b1;
            w_state_n   = STALL;
          end
        end
      end

      STALL: begin
        if (i_redirect) begin
          w_pc_n    = i_pc_selected;
          w_state_n = FETCH;
        end else if (i_d_ready) begin
          w_f_n        = w_skid;
          w_skid_drain = 1'b1;
          w_state_n    = FETCH;
        end
      end

      FLUSH: begin
        if (i_iresp_data_ok) begin
          // Stale response is dropped; a same-cycle redirect target wins.
          w_pc_n    = i_redirect ? i_pc_selected : r_pc_pending;
          w_state_n = FETCH;
        end else if (i_redirect) begin
          w_pc_pending_n = i_pc_selected;
        end
      end

      default: begin
        w_state_n = FETCH;
      end
    endcase
  end

  assign o_f_valid = r_f.valid;
  assign o_f_pc    = r_f.pc;
  assign o_f_instr = r_f.instr;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl
module tb_ifetch_ctrl;
  import common::*;

  localparam u64 PC_RST = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic [63:0] pcplus4;
  logic [63:0] pc_selected;
  logic        redirect;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        d_ready;

  int errors = 0;
  int checks = 0;

  ifetch_ctrl #(.PC_RESET(PC_RST)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .o_pcplus4       (pcplus4),
    .i_pc_selected   (pc_selected),
    .i_redirect      (redirect),
    .o_ireq_valid    (ireq_valid),
    .o_ireq_addr     (ireq_addr),
    .i_iresp_data_ok (iresp_data_ok),
    .i_iresp_data    (iresp_data),
    .o_f_valid       (f_valid),
    .o_f_pc          (f_pc),
    .o_f_instr       (f_instr),
    .i_d_ready       (d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic u32 memword(input u64 a);
    return a[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  // Transaction-level reference: buffered instructions in a queue (front is
  // what decode sees), the address of the next fetch, and whether the fetch
  // in flight belongs to a path abandoned by a redirect.
  fetch_out_t m_q[$];
  u64         m_addr;
  logic       m_stale;
  u64         m_resume;

  function automatic logic m_req();
    return m_q.size() < 2;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_addr   = PC_RST;
    m_stale  = 1'b0;
    m_resume = '0;
  endtask

  task automatic m_step(input logic dok, input u32 data, input logic redir,
                        input u64 tgt, input logic drdy);
    logic req;
    req = m_req();
    if (redir) begin
      m_q.delete();
      if (req && dok) begin
        m_addr  = tgt;
        m_stale = 1'b0;
      end else if (req) begin
        m_stale  = 1'b1;
        m_resume = tgt;
      end else begin
        m_addr = tgt;
      end
    end else begin
      if (drdy && m_q.size() > 0) void'(m_q.pop_front());
      if (req && dok) begin
        if (m_stale) begin
          m_addr  = m_resume;
          m_stale = 1'b0;
        end else begin
          m_q.push_back('{valid: 1'b1, pc: m_addr, instr: data});
          m_addr = m_addr + 64'd4;
        end
      end
    end
  endtask

  task automatic m_compare(input string tag);
    chk({tag, ".ireq_valid"}, {63'd0, ireq_valid}, {63'd0, m_req()});
    chk({tag, ".ireq_addr"}, ireq_addr, m_addr);
    chk({tag, ".pcplus4"}, pcplus4, m_addr + 64'd4);
    chk({tag, ".f_valid"}, {63'd0, f_valid}, {63'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      chk({tag, ".f_pc"}, f_pc, m_q[0].pc);
      chk({tag, ".f_instr"}, {32'd0, f_instr}, {32'd0, m_q[0].instr});
    end
  endtask

  typedef struct {
    logic dok;
    logic redir;
    u64   tgt;
    logic drdy;
    logic e_req;
    u64   e_addr;
    logic e_fv;
    u64   e_fpc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    u64 cur;
    logic dok, redir, drdy;
    u64 tgt;
    u32 data;

    //               dok redir tgt             drdy req addr            fv fpc
    tbl[0]  = '{1'b1, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
    tbl[1]  = '{1'b1, 1'b0, 64'h0,           1'b0, 1'b0, 64'h8000_0008, 1'b1, 64'h8000_0000};
    tbl[2]  = '{1'b0, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
    tbl[3]  = '{1'b1, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};
    tbl[4]  = '{1'b1, 1'b1, 64'h8000_0100,   1'b1, 1'b1, 64'h8000_0100, 1'b0, 64'h0};
    tbl[5]  = '{1'b1, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0104, 1'b1, 64'h8000_0100};
    tbl[6]  = '{1'b1, 1'b1, 64'h8000_0010,   1'b1, 1'b1, 64'h8000_0010, 1'b0, 64'h0};
    tbl[7]  = '{1'b0, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0010, 1'b0, 64'h0};
    tbl[8]  = '{1'b0, 1'b1, 64'h8000_0200,   1'b1, 1'b1, 64'h8000_0010, 1'b0, 64'h0};
    tbl[9]  = '{1'b0, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0010, 1'b0, 64'h0};
    tbl[10] = '{1'b0, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0010, 1'b0, 64'h0};
    tbl[11] = '{1'b1, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0200, 1'b0, 64'h0};
    tbl[12] = '{1'b1, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0204, 1'b1, 64'h8000_0200};
    tbl[13] = '{1'b0, 1'b1, 64'h8000_0200,   1'b1, 1'b1, 64'h8000_0204, 1'b0, 64'h0};
    tbl[14] = '{1'b0, 1'b1, 64'h8000_0300,   1'b1, 1'b1, 64'h8000_0204, 1'b0, 64'h0};
    tbl[15] = '{1'b1, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0300, 1'b0, 64'h0};
    tbl[16] = '{1'b1, 1'b0, 64'h0,           1'b1, 1'b1, 64'h8000_0304, 1'b1, 64'h8000_0300};
    tbl[17] = '{1'b0, 1'b1, 64'h8000_0400,   1'b1, 1'b1, 64'h8000_0304, 1'b0, 64'h0};

    reset         = 1'b1;
    redirect      = 1'b0;
    pc_selected   = '0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    d_ready       = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst.f_valid", {63'd0, f_valid}, 64'd0);
    chk("rst.f_pc", f_pc, 64'd0);
    chk("rst.f_instr", {32'd0, f_instr}, 64'd0);
    chk("rst.ireq_addr", ireq_addr, PC_RST);
    chk("rst.pcplus4", pcplus4, PC_RST + 64'd4);

    reset = 1'b0;
    #1;
    chk("rel.ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("rel.ireq_addr", ireq_addr, PC_RST);

    cur = PC_RST;
    for (int i = 0; i < 18; i++) begin
      iresp_data_ok = tbl[i].dok;
      iresp_data    = memword(cur);
      redirect      = tbl[i].redir;
      pc_selected   = tbl[i].redir ? tbl[i].tgt : cur + 64'd4;
      d_ready       = tbl[i].drdy;
      @(negedge clk);
      chk($sformatf("v%0d.ireq_valid", i), {63'd0, ireq_valid}, {63'd0, tbl[i].e_req});
      chk($sformatf("v%0d.ireq_addr", i), ireq_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.f_valid", i), {63'd0, f_valid}, {63'd0, tbl[i].e_fv});
      if (tbl[i].e_fv) begin
        chk($sformatf("v%0d.f_pc", i), f_pc, tbl[i].e_fpc);
        chk($sformatf("v%0d.f_instr", i), {32'd0, f_instr}, {32'd0, memword(tbl[i].e_fpc)});
      end
      cur = tbl[i].e_addr;
    end

    // Reset in the middle of a flush abandons the request at once.
    iresp_data_ok = 1'b0;
    redirect      = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("midrst.f_valid", {63'd0, f_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst.ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("postrst.ireq_addr", ireq_addr, PC_RST);

    // Randomized traffic against the reference model.
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      m_compare($sformatf("r%0d", n));
      drdy  = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 9) == 0);
      tgt   = {32'd0, 32'h8000_0000 + ($urandom_range(0, 4095) << 2)};
      dok   = m_req() && ($urandom_range(0, 2) != 0);
      data  = $urandom;
      iresp_data_ok = dok;
      iresp_data    = data;
      redirect      = redir;
      pc_selected   = redir ? tgt : m_addr + 64'd4;
      d_ready       = drdy;
      m_step(dok, data, redir, tgt, drdy);
      @(negedge clk);
    end
    m_compare("rend");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
